// File: rtl/isp_boot_controller.sv
// Boot sequencer: parses LOAD/RUN frames from a host byte stream, streams words into
// program memory while holding the core in reset, then releases it with a start pulse.
module isp_boot_controller #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_BITS   = 12,
  parameter int         PROG_ADDR_BITS = 20,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] CMD_LOAD       = 8'hA5,
  parameter logic [7:0] CMD_RUN        = 8'h5A
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      core_reset,
  output logic                      isp_write,
  output logic [ADDRESS_BITS-1:0]   isp_address,
  output logic [DATA_WIDTH-1:0]     isp_data,
  output logic                      start,
  output logic [PROG_ADDR_BITS-1:0] prog_address,
  output logic                      busy,
  output logic                      error,
  output logic [1:0]                error_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HDR_ADDR, HDR_CNT, DATA, RUN_ADDR, RUN_GO} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                byte_idx_q, byte_idx_d;
  logic [23:0]               shift_q, shift_d;
  logic [31:0]               base_q, base_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               word_cnt_q, word_cnt_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      core_reset_q, core_reset_d;
  logic                      isp_write_q, isp_write_d;
  logic [ADDRESS_BITS-1:0]   isp_address_q, isp_address_d;
  logic [DATA_WIDTH-1:0]     isp_data_q, isp_data_d;
  logic                      start_q, start_d;
  logic [PROG_ADDR_BITS-1:0] prog_address_q, prog_address_d;
  logic                      busy_q, busy_d;
  logic                      error_q, error_d;
  logic [1:0]                error_code_q, error_code_d;

  logic        accept;
  logic        in_rx;
  logic        last_byte;
  logic [31:0] word;

  assign accept    = rx_valid && rx_ready_q;
  assign in_rx     = (state_q == HDR_ADDR) || (state_q == HDR_CNT) ||
                     (state_q == DATA) || (state_q == RUN_ADDR);
  assign last_byte = (byte_idx_q == 2'd3);
  // Little-endian assembly: the byte arriving now is the most significant.
  assign word      = {rx_data, shift_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    base_d         = base_q;
    count_d        = count_q;
    word_cnt_d     = word_cnt_q;
    core_reset_d   = core_reset_q;
    isp_write_d    = 1'b0;
    isp_address_d  = isp_address_q;
    isp_data_d     = isp_data_q;
    start_d        = 1'b0;
    prog_address_d = prog_address_q;
    busy_d         = busy_q;
    error_d        = error_q;
    error_code_d   = error_code_q;
    timer_d        = (in_rx && !accept) ? timer_q + TW'(1) : '0;

    if (in_rx && accept) begin
      shift_d    = {rx_data, shift_q[23:8]};
      byte_idx_d = byte_idx_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          byte_idx_d = 2'd0;
          if (rx_data == CMD_LOAD || rx_data == CMD_RUN) begin
            state_d      = (rx_data == CMD_LOAD) ? HDR_ADDR : RUN_ADDR;
            busy_d       = 1'b1;
            error_d      = 1'b0;
            error_code_d = 2'b00;
            if (rx_data == CMD_LOAD) core_reset_d = 1'b1;
          end else begin
            error_d      = 1'b1;
            error_code_d = 2'b01;
          end
        end
      end
      HDR_ADDR: begin
        if (accept && last_byte) begin
          base_d  = word;
          state_d = HDR_CNT;
        end
      end
      HDR_CNT: begin
        if (accept && last_byte) begin
          count_d    = word;
          word_cnt_d = '0;
          if (word == 32'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && last_byte) begin
          isp_write_d   = 1'b1;
          isp_address_d = base_q[ADDRESS_BITS-1:0] + word_cnt_q[ADDRESS_BITS-1:0];
          isp_data_d    = word[DATA_WIDTH-1:0];
          word_cnt_d    = word_cnt_q + 32'd1;
          if (word_cnt_d == count_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      RUN_ADDR: begin
        if (accept && last_byte) begin
          state_d        = RUN_GO;
          start_d        = 1'b1;
          core_reset_d   = 1'b0;
          prog_address_d = word[PROG_ADDR_BITS-1:0];
        end
      end
      RUN_GO: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort takes priority; a partially assembled word is simply dropped.
    if (in_rx && !accept && timer_q == TIMEOUT_LAST) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      error_d      = 1'b1;
      error_code_d = 2'b10;
      isp_write_d  = 1'b0;
      timer_d      = '0;
    end

    rx_ready_d = (state_d != RUN_GO);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      byte_idx_q     <= '0;
      shift_q        <= '0;
      base_q         <= '0;
      count_q        <= '0;
      word_cnt_q     <= '0;
      timer_q        <= '0;
      rx_ready_q     <= 1'b0;
      core_reset_q   <= 1'b1;
      isp_write_q    <= 1'b0;
      isp_address_q  <= '0;
      isp_data_q     <= '0;
      start_q        <= 1'b0;
      prog_address_q <= '0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= 2'b00;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      base_q         <= base_d;
      count_q        <= count_d;
      word_cnt_q     <= word_cnt_d;
      timer_q        <= timer_d;
      rx_ready_q     <= rx_ready_d;
      core_reset_q   <= core_reset_d;
      isp_write_q    <= isp_write_d;
      isp_address_q  <= isp_address_d;
      isp_data_q     <= isp_data_d;
      start_q        <= start_d;
      prog_address_q <= prog_address_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      error_code_q   <= error_code_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign core_reset   = core_reset_q;
  assign isp_write    = isp_write_q;
  assign isp_address  = isp_address_q;
  assign isp_data     = isp_data_q;
  assign start        = start_q;
  assign prog_address = prog_address_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign error_code   = error_code_q;

endmodule
